// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
//   Shared constants and types for scanned seven-segment display logic.
//   BCD_W       : width of one BCD digit code
//   BLANK_CODE  : code the downstream decoder renders with all segments off
//   scan_state_t: per-slot scan phase (blanking guard, then digit shown)
// ---------------------------------------------------------------------------
package display_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage : display_pkg

// File: rtl/scan_prescaler.sv
// ---------------------------------------------------------------------------
// scan_prescaler
//   Free-running slot counter for scanned peripherals (displays, keypads).
//   cnt runs 0..DIV-1 and wraps; tick marks the last cycle of each slot.
//
//   Ports:
//     clk  in   system clock
//     rst  in   synchronous reset, active-high (cnt -> 0)
//     clr  in   synchronous clear, holds cnt at 0 while high
//     tick out  high while cnt == DIV-1
//     cnt  out  current position inside the slot
// ---------------------------------------------------------------------------
module scan_prescaler #(
  parameter int DIV   = 50000,
  parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             last_cycle;

  assign last_cycle = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (last_cycle) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // tick is decoded from the counter register only, so it carries no
  // combinational path from clr into the consumer.
  assign tick = last_cycle;
  assign cnt  = cnt_reg;

endmodule : scan_prescaler

// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//   Time-multiplexed scan controller for a common-cathode seven-segment
//   display. One digit is selected per slot; its BCD code goes to a shared
//   external decoder. Every slot opens with a blanking guard so the previous
//   digit's segments never ghost onto the next one. The displayed value is
//   double-buffered (shadow -> active) and only changes at frame boundaries.
//
//   Ports:
//     clk            in   system clock
//     rst            in   synchronous reset, active-high
//     en             in   scan enable; low = display dark, scan held at idx 0
//     load           in   one-cycle strobe capturing din into the shadow
//     din            in   NUM_DIGITS BCD digits, [3:0] = rightmost digit 0
//     lz_en          in   leading-zero suppression enable
//     bcd_out        out  code for the shared decoder, 4'hF = blank
//     digit_en       out  one-hot digit enable, zero during guard/disabled
//     update_pending out  shadow holds a value not yet committed
//     frame_done     out  one-cycle pulse after the last slot of a frame
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] din,
  input  logic                        lz_en,
  output logic [BCD_W-1:0]            bcd_out,
  output logic [NUM_DIGITS-1:0]       digit_en,
  output logic                        update_pending,
  output logic                        frame_done
);

  localparam int DATA_W = BCD_W * NUM_DIGITS;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(BLANK_CYCLES - 1);

  // -------------------------------------------------------------------------
  // Slot timing
  // -------------------------------------------------------------------------
  logic             tick;
  logic [CNT_W-1:0] cnt;

  // Holding the prescaler clear while disabled means re-enabling always
  // starts a fresh slot with a full guard period.
  scan_prescaler #(
    .DIV   (REFRESH_DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (~en),
    .tick (tick),
    .cnt  (cnt)
  );

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  scan_state_t           state_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [DATA_W-1:0]     shadow_reg;
  logic [DATA_W-1:0]     active_reg;
  logic                  pending_reg;
  logic [NUM_DIGITS-1:0] digit_en_reg;
  logic [BCD_W-1:0]      bcd_reg;
  logic                  frame_done_reg;

  // -------------------------------------------------------------------------
  // Per-digit decode of the active value
  // -------------------------------------------------------------------------
  logic [BCD_W-1:0]      digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] suppress;
  logic [NUM_DIGITS-1:0] onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = active_reg[gi*BCD_W +: BCD_W];
      assign onehot[gi]    = (idx_reg == IDX_W'(gi));

      if (gi == 0) begin : g_rightmost
        // The rightmost digit always shows so a zero value reads "0".
        assign suppress[gi] = 1'b0;
      end else begin : g_upper
        // A digit is a leading zero when it and everything to its left is 0.
        assign suppress[gi] = lz_en &&
                              (active_reg[DATA_W-1:gi*BCD_W] == '0);
      end
    end
  endgenerate

  logic [BCD_W-1:0] cur_digit;
  logic             cur_suppress;

  assign cur_digit    = digit_arr[idx_reg];
  assign cur_suppress = suppress[idx_reg];

  // -------------------------------------------------------------------------
  // Scan FSM, buffers and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= GUARD;
      idx_reg        <= '0;
      shadow_reg     <= '0;
      active_reg     <= '0;
      pending_reg    <= 1'b0;
      digit_en_reg   <= '0;
      bcd_reg        <= BLANK_CODE;
      frame_done_reg <= 1'b0;
    end else if (!en) begin
      // Display dark; nothing is being scanned so there is no tearing risk
      // and a load goes straight to the active buffer.
      state_reg      <= GUARD;
      idx_reg        <= '0;
      digit_en_reg   <= '0;
      bcd_reg        <= BLANK_CODE;
      frame_done_reg <= 1'b0;
      if (load) begin
        shadow_reg  <= din;
        active_reg  <= din;
        pending_reg <= 1'b0;
      end
    end else begin
      // Outputs reflect the state held during the previous cycle.
      frame_done_reg <= 1'b0;
      digit_en_reg   <= (state_reg == SHOW) ? onehot : '0;
      bcd_reg        <= ((state_reg == SHOW) && !cur_suppress) ? cur_digit
                                                               : BLANK_CODE;

      if (tick) begin
        state_reg <= GUARD;
        if (idx_reg == LAST_IDX) begin
          idx_reg        <= '0;
          frame_done_reg <= 1'b1;
          if (pending_reg) begin
            active_reg  <= shadow_reg;
            pending_reg <= 1'b0;
          end
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end else if ((state_reg == GUARD) && (cnt == GUARD_LAST)) begin
        state_reg <= SHOW;
      end

      // Placed after the commit so a load on the commit tick re-arms
      // pending: the old shadow is committed, the new din waits a frame.
      if (load) begin
        shadow_reg  <= din;
        pending_reg <= 1'b1;
      end
    end
  end

  assign bcd_out        = bcd_reg;
  assign digit_en       = digit_en_reg;
  assign update_pending = pending_reg;
  assign frame_done     = frame_done_reg;

endmodule : seven_seg_scan_ctrl

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic          load;
  logic [15:0]   din;
  logic          lz_en;
  logic [3:0]    bcd_out;
  logic [N-1:0]  digit_en;
  logic          update_pending;
  logic          frame_done;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .load           (load),
    .din            (din),
    .lz_en          (lz_en),
    .bcd_out        (bcd_out),
    .digit_en       (digit_en),
    .update_pending (update_pending),
    .frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected digit display: enable pattern, code, and the number of dark
  // cycles that must precede it (-1 = not checked).
  typedef struct {
    logic [3:0] den;
    logic [3:0] bcd;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   zero_run = 0;
  logic [N-1:0] prev_en = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic push_item(input logic [3:0] den, input logic [3:0] bcd,
                           input int gap);
    exp_t e;
    e.den = den;
    e.bcd = bcd;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // word holds the hand-computed code per digit, [3:0] = idx0, F = blank.
  task automatic push_frame(input logic [15:0] word, input int first_gap);
    for (int i = 0; i < N; i++) begin
      push_item(4'(1 << i), word[i*4 +: 4], (i == 0) ? first_gap : 2);
    end
  endtask

  task automatic wait_frame(output int cycles);
    logic found;
    found  = 1'b0;
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cycles++;
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    check("frame_done_seen", 32'(found), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] value);
    din  = value;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    en    = 1'b0;
    load  = 1'b0;
    din   = '0;
    lz_en = 1'b0;

    fork
      begin : stimulus
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_digit_en", 32'(digit_en), 32'h0);
        check("rst_bcd", 32'(bcd_out), 32'hF);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_pending", 32'(update_pending), 32'h0);
        rst = 1'b0;

        // Load while disabled goes straight to active.
        do_load(16'h1234);
        @(negedge clk);
        check("dis_load_pending", 32'(update_pending), 32'h0);
        push_frame(16'h1234, -1);
        en = 1'b1;
        wait_frame(n);
        push_frame(16'h1234, 2);
        wait_frame(n);
        check("frame_period", 32'(n), 32'd32);

        // Load mid-frame (idx1 slot) stays hidden until the frame ends.
        push_frame(16'h1234, 2);
        repeat (10) @(posedge clk);
        #1;
        do_load(16'h5678);
        @(negedge clk);
        check("mid_load_pending", 32'(update_pending), 32'h1);
        wait_frame(n);
        check("commit_pending_clr", 32'(update_pending), 32'h0);
        push_frame(16'h5678, 2);
        wait_frame(n);

        // Leading-zero suppression.
        lz_en = 1'b1;
        push_frame(16'h5678, 2);
        do_load(16'h0070);
        wait_frame(n);
        push_frame(16'hFF70, 2);
        wait_frame(n);
        lz_en = 1'b0;
        push_frame(16'h0070, 2);
        do_load(16'h0000);
        wait_frame(n);
        lz_en = 1'b1;
        push_frame(16'hFFF0, 2);
        do_load(16'h1111);
        do_load(16'h2222);
        wait_frame(n);
        check("b2b_pending_clr", 32'(update_pending), 32'h0);

        // Load exactly on the commit tick (cycle 31 of the frame).
        push_frame(16'h2222, 2);
        do_load(16'h4444);
        repeat (30) @(posedge clk);
        #1;
        din  = 16'h9999;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        check("tick_load_frame_done", 32'(frame_done), 32'h1);
        check("tick_load_pending", 32'(update_pending), 32'h1);
        push_frame(16'h4444, 2);
        wait_frame(n);
        check("tick_load_pending_clr", 32'(update_pending), 32'h0);
        push_frame(16'h9999, 2);
        wait_frame(n);

        // Reset in the middle of the idx2 SHOW phase.
        push_item(4'b0001, 4'h9, 2);
        push_item(4'b0010, 4'h9, 2);
        push_item(4'b0100, 4'h9, 2);
        do_load(16'h1357);
        check("pre_rst_pending", 32'(update_pending), 32'h1);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_digit_en", 32'(digit_en), 32'h0);
        check("mid_rst_bcd", 32'(bcd_out), 32'hF);
        check("mid_rst_pending", 32'(update_pending), 32'h0);
        rst = 1'b0;
        // One reset cycle plus the two guard cycles of the restarted slot.
        push_frame(16'hFFF0, 3);
        wait_frame(n);

        // Drop en in the middle of the idx0 SHOW phase.
        push_item(4'b0001, 4'h0, 2);
        repeat (5) @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("en_drop_digit_en", 32'(digit_en), 32'h0);
        check("en_drop_bcd", 32'(bcd_out), 32'hF);
        do_load(16'h0005);
        @(negedge clk);
        check("en_low_load_pending", 32'(update_pending), 32'h0);
        en = 1'b1;
        push_frame(16'hFFF5, -1);
        wait_frame(n);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
      end

      begin : monitor
        forever begin
          @(negedge clk);
          if ((digit_en != '0) && (prev_en == '0)) begin
            if (exp_q.size() == 0) begin
              check("unexpected_display", 32'(digit_en), 32'h0);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              check("disp_digit_en", 32'(digit_en), 32'(e.den));
              check("disp_bcd", 32'(bcd_out), 32'(e.bcd));
              if (e.gap >= 0) begin
                check("disp_guard_gap", 32'(zero_run), 32'(e.gap));
              end
            end
          end
          if (digit_en == '0) zero_run++;
          else                zero_run = 0;
          prev_en = digit_en;
        end
      end
    join_any

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seven_seg_scan_ctrl

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an NUM_DIGITS common-cathode seven-segment display. All digits share one BCD-to-segment decoder; that decoder stays outside this block.
The block selects one digit at a time and presents its BCD code on bcd_out. It drives the one-hot digit enable and inserts a blanking guard at each digit change to prevent ghosting.
The displayed value is double-buffered and updates only at frame boundaries, so the display never tears. Optional leading-zero suppression is provided.

Parameters:
NUM_DIGITS, 4, number of digits scanned; range 2..8
REFRESH_DIV, 50000, clk cycles per digit slot; must be > BLANK_CYCLES
BLANK_CYCLES, 16, guard cycles at the start of each slot with all digit enables off; must be >= 1

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  synchronous reset, active-high
en  input  1  scan enable; 0 = display dark and scan held
load  input  1  single-cycle strobe that captures din
din  input  4*NUM_DIGITS  BCD digits; [3:0] is digit 0 (rightmost, least significant)
lz_en  input  1  leading-zero suppression enable
bcd_out  output  4  code to the shared decoder; 4'hF = blank (decoder shows all segments off for codes >= 10)
digit_en  output  NUM_DIGITS  one-hot digit enable, active-high; all-zero during guard or when disabled
update_pending  output  1  shadow holds a value not yet committed
frame_done  output  1  one-cycle pulse on the cycle a frame completes

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - digit_en=0, bcd_out=4'hF, frame_done=0, update_pending=0
  - shadow=0, active=0
  - slot counter cnt=0, digit index idx=0, FSM=GUARD
  - Reset has priority over every other input.
- Slot counter:
  - cnt counts 0..REFRESH_DIV-1 while en=1.
  - tick = (cnt==REFRESH_DIV-1); on tick, cnt wraps to 0.
  - On tick, idx advances (idx==NUM_DIGITS-1 wraps to 0).
- FSM, two states:
  - GUARD: entered on reset, on every tick, and whenever en=0. Moves to SHOW when cnt==BLANK_CYCLES-1.
  - SHOW: lasts until the next tick.
  - Each slot is exactly BLANK_CYCLES GUARD cycles followed by REFRESH_DIV-BLANK_CYCLES SHOW cycles.
- Outputs are registered (one cycle after the state that produces them):
  - digit_en = one-hot(idx) in SHOW, else 0.
  - bcd_out = active digit[idx], or 4'hF if suppressed; forced to 4'hF in GUARD.
- Leading-zero suppression (lz_en=1):
  - Digit idx>0 is suppressed when digits idx..NUM_DIGITS-1 of active are all 4'h0.
  - Digit 0 is never suppressed.
  - lz_en=0 shows all digits unmodified. Codes 10..15 in din pass through unchanged.
- Load and commit:
  - load=1: shadow<=din and update_pending<=1. A later load before commit overwrites the shadow (last wins).
  - Commit happens on a tick with idx==NUM_DIGITS-1: if update_pending then active<=shadow and update_pending<=0.
  - frame_done pulses on that same tick, whether or not anything was pending.
  - If load coincides with a commit tick: the old shadow is committed, then the new din is captured and update_pending stays 1 for the next frame.
- en=0:
  - cnt=0, idx=0, GUARD; digit_en=0 and bcd_out=4'hF on the next cycle; frame_done=0.
  - load writes shadow and active together, with update_pending=0.
- en 0->1: scanning restarts at idx 0 with a full guard period.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package (display_pkg):
  - BLANK_CODE = 4'hF
  - BCD digit width = 4
  - state encoding GUARD=1'b0, SHOW=1'b1
- Sub-module scan_prescaler: the cnt/tick generator with synchronous clear (inputs clk, rst, clr; output tick, cnt). It is reusable for future scanned keypads.
- Keep this block separate from the decoder. The top level wires bcd_out into the decoder and gates the segments with digit_en externally.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset release with en=0, then load din=16'h1234, then en=1 -> per 8-cycle slot: 2 cycles digit_en=0000/bcd F, then 6 cycles of 0001/4, then 0010/3, 0100/2, 1000/1, repeating; frame_done pulses every 32 cycles.
2. With 16'h1234 displayed, load 16'h5678 during the idx=1 slot -> update_pending=1 and digits stay 1234 until the frame_done cycle; the next frame shows 8,7,6,5 and update_pending=0.
3. lz_en=1, active=16'h0070 -> idx0 bcd 0, idx1 bcd 7, idx2 F, idx3 F; with lz_en=0 the same value gives 0,7,0,0.
4. lz_en=1, active=16'h0000 -> idx0 shows 0, idx1..3 show F; back-to-back loads 16'h1111 then 16'h2222 in one frame -> only 2222 is committed.
5. load asserted on the commit tick with din=16'h9999 while shadow=16'h4444 pending -> next frame shows 4444 with update_pending still 1; the frame after shows 9999.
6. rst pulsed mid-SHOW at idx=2 -> next cycle digit_en=0, bcd_out=F, update_pending=0; after release, scan restarts at idx0 with 2 guard cycles. en dropped mid-slot -> digit_en=0 next cycle.
